audio_byte_scheduler: RTL and testbench

Shares the single audio byte sink (the serial song byte sender path) between two requesters: the background-music byte stream and the sound-effect (brick/paddle/wall hit) byte stream.
- Grants one byte at a time: SFX has priority, with a starvation guard so music always progresses.
- Enforces a programmable minimum gap between bytes (tempo pacing).
- Sits between the AXI4-Lite song register block and the byte sender, in the ACLK domain.

---
 rtl/audio_sched_pkg.sv | 20 ++
 rtl/audio_pace_timer.sv | 29 ++
 rtl/audio_byte_scheduler.sv | 125 ++++++++++++
 tb/tb_audio_byte_scheduler.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_sched_pkg.sv
// rtl/audio_sched_pkg.sv - shared types and constants for the audio byte scheduler
package audio_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } sched_state_t;

  localparam logic SRC_MUSIC = 1'b0;
  localparam logic SRC_SFX   = 1'b1;

  localparam int PACE_W_DEFAULT = 16;

  // Bits needed to hold a saturating run count of 0..max_run.
  function automatic int run_cnt_width(input int max_run);
    return (max_run < 1) ? 1 : $clog2(max_run + 1);
  endfunction

endpackage

// File: rtl/audio_pace_timer.sv
// rtl/audio_pace_timer.sv - loadable down-counter that times the inter-byte gap
module audio_pace_timer
  import audio_sched_pkg::*;
#(
  parameter int PACE_W = PACE_W_DEFAULT
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              load,
  input  logic [PACE_W-1:0] load_val,
  output logic              done
);

  logic [PACE_W-1:0] r_cnt;

  // Load on request, otherwise count down and rest at zero.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign done = (r_cnt == '0);

endmodule

// File: rtl/audio_byte_scheduler.sv
// rtl/audio_byte_scheduler.sv - arbitrates music and SFX bytes onto the single audio byte sink
module audio_byte_scheduler
  import audio_sched_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PACE_W      = PACE_W_DEFAULT,
  parameter int MAX_SFX_RUN = 3
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              enable,
  input  logic [PACE_W-1:0] pace_cycles,
  input  logic              music_valid,
  input  logic [DATA_W-1:0] music_byte,
  output logic              music_ready,
  input  logic              sfx_valid,
  input  logic [DATA_W-1:0] sfx_byte,
  output logic              sfx_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_byte,
  output logic              out_src,
  input  logic              out_ready,
  output logic              busy
);

  localparam int RUN_W = run_cnt_width(MAX_SFX_RUN);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_SFX_RUN);

  sched_state_t      r_state;
  sched_state_t      w_next_state;
  logic [RUN_W-1:0]  r_run_cnt;
  logic [DATA_W-1:0] r_out_byte;
  logic              r_out_src;

  logic              w_grant;
  logic              w_pick_sfx;
  logic              w_pace_load;
  logic [PACE_W-1:0] w_pace_load_val;
  logic              w_pace_done;

  // A grant is only possible from IDLE while enabled and out of reset, so
  // readies stay low while ARESETN is held even though state reads IDLE.
  assign w_grant    = ARESETN && enable && (r_state == IDLE) && (music_valid || sfx_valid);
  assign w_pick_sfx = sfx_valid && (!music_valid || (r_run_cnt < RUN_MAX));

  // The gap counter is loaded with pace-1 because the SEND exit edge itself
  // starts the first idle cycle.
  assign w_pace_load_val = pace_cycles - 1'b1;

  audio_pace_timer #(
    .PACE_W (PACE_W)
  ) u_pace_timer (
    .ACLK     (ACLK),
    .ARESETN  (ARESETN),
    .load     (w_pace_load),
    .load_val (w_pace_load_val),
    .done     (w_pace_done)
  );

  // State register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: grant -> SEND -> (optional GAP) -> IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_next_state = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          w_next_state = (pace_cycles == '0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (w_pace_done) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs decoded from state: one-hot readies in the grant cycle, valid in SEND.
  always_comb begin
    music_ready = w_grant && !w_pick_sfx;
    sfx_ready   = w_grant && w_pick_sfx;
    out_valid   = (r_state == SEND);
    busy        = (r_state != IDLE);
    w_pace_load = (r_state == SEND) && out_ready && (pace_cycles != '0);
  end

  // Capture the granted byte and track consecutive SFX grants.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_out_byte <= '0;
      r_out_src  <= SRC_MUSIC;
      r_run_cnt  <= '0;
    end else if (w_grant) begin
      if (w_pick_sfx) begin
        r_out_byte <= sfx_byte;
        r_out_src  <= SRC_SFX;
        if (r_run_cnt != RUN_MAX) begin
          r_run_cnt <= r_run_cnt + 1'b1;
        end
      end else begin
        r_out_byte <= music_byte;
        r_out_src  <= SRC_MUSIC;
        r_run_cnt  <= '0;
      end
    end
  end

  assign out_byte = r_out_byte;
  assign out_src  = r_out_src;

endmodule

// File: tb/tb_audio_byte_scheduler.sv
// tb/tb_audio_byte_scheduler.sv - self-checking bench for audio_byte_scheduler
module tb_audio_byte_scheduler;

  localparam int DATA_W  = 8;
  localparam int PACE_W  = 16;
  localparam int MAX_RUN = 3;

  logic              ACLK = 1'b0;
  logic              ARESETN = 1'b0;
  logic              enable = 1'b0;
  logic [PACE_W-1:0] pace_cycles = '0;
  logic              music_valid = 1'b0;
  logic [DATA_W-1:0] music_byte = '0;
  logic              sfx_valid = 1'b0;
  logic [DATA_W-1:0] sfx_byte = '0;
  logic              out_ready = 1'b0;
  logic              music_ready;
  logic              sfx_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_byte;
  logic              out_src;
  logic              busy;

  always #5 ACLK = ~ACLK;

  audio_byte_scheduler #(
    .DATA_W      (DATA_W),
    .PACE_W      (PACE_W),
    .MAX_SFX_RUN (MAX_RUN)
  ) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .enable      (enable),
    .pace_cycles (pace_cycles),
    .music_valid (music_valid),
    .music_byte  (music_byte),
    .music_ready (music_ready),
    .sfx_valid   (sfx_valid),
    .sfx_byte    (sfx_byte),
    .sfx_ready   (sfx_ready),
    .out_valid   (out_valid),
    .out_byte    (out_byte),
    .out_src     (out_src),
    .out_ready   (out_ready),
    .busy        (busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a byte is outstanding or not, and the sink is free again
  // once the gap after the last accepted byte has elapsed.
  int         cyc = 0;
  bit         m_send = 1'b0;
  logic [7:0] m_byte = '0;
  logic       m_src = 1'b0;
  int         m_run = 0;
  int         m_free_at = 0;
  logic [8:0] got_q[$];
  int         grant_cyc_q[$];
  bit         took_m = 1'b0;
  bit         took_s = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: entered at a negedge with inputs already driven.
  task automatic tick();
    bit free;
    bit e_sfx;
    bit e_mus;
    #1;
    if (!ARESETN) begin
      check("rst_music_ready", 32'(music_ready), 0);
      check("rst_sfx_ready", 32'(sfx_ready), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_byte", 32'(out_byte), 0);
      check("rst_out_src", 32'(out_src), 0);
      check("rst_busy", 32'(busy), 0);
      m_send = 1'b0;
      m_run = 0;
      m_free_at = cyc;
    end else begin
      free  = !m_send && (cyc >= m_free_at);
      e_sfx = free && enable && sfx_valid && (!music_valid || m_run < MAX_RUN);
      e_mus = free && enable && music_valid && !e_sfx;
      check("sfx_ready", 32'(sfx_ready), 32'(e_sfx));
      check("music_ready", 32'(music_ready), 32'(e_mus));
      check("out_valid", 32'(out_valid), 32'(m_send));
      check("busy", 32'(busy), 32'(!free));
      if (m_send) begin
        check("out_byte", 32'(out_byte), 32'(m_byte));
        check("out_src", 32'(out_src), 32'(m_src));
        if (out_ready) begin
          m_send = 1'b0;
          got_q.push_back({m_src, m_byte});
          m_free_at = cyc + 1 + int'(pace_cycles);
        end
      end else if (e_sfx || e_mus) begin
        m_send = 1'b1;
        grant_cyc_q.push_back(cyc);
        if (e_sfx) begin
          m_byte = sfx_byte;
          m_src  = 1'b1;
          m_run  = (m_run < MAX_RUN) ? m_run + 1 : MAX_RUN;
        end else begin
          m_byte = music_byte;
          m_src  = 1'b0;
          m_run  = 0;
        end
      end
    end
    took_m = music_ready;
    took_s = sfx_ready;
    @(negedge ACLK);
    cyc++;
    if (took_m) music_valid = 1'b0;
    if (took_s) sfx_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 300 && (m_send || music_valid || sfx_valid || cyc < m_free_at); i++) begin
      tick();
    end
    check("drain_timeout", 32'(i < 300), 1);
  endtask

  logic [8:0] exp4[5];
  int         nxt;

  initial begin
    @(negedge ACLK);
    // Reset with both requesters valid: everything quiet.
    enable = 1'b1; music_valid = 1'b1; music_byte = 8'hE1;
    sfx_valid = 1'b1; sfx_byte = 8'hE2;
    repeat (3) tick();
    music_valid = 1'b0; sfx_valid = 1'b0;
    ARESETN = 1'b1;
    tick();

    // Music only, pace 4.
    got_q.delete(); grant_cyc_q.delete();
    pace_cycles = 16'd4; out_ready = 1'b1;
    music_valid = 1'b1; music_byte = 8'h11;
    tick();
    music_valid = 1'b1; music_byte = 8'h22;
    drain();
    check("t2_count", 32'(got_q.size()), 2);
    if (got_q.size() >= 2 && grant_cyc_q.size() >= 2) begin
      check("t2_byte0", 32'(got_q[0]), 32'h011);
      check("t2_byte1", 32'(got_q[1]), 32'h022);
      check("t2_period", 32'(grant_cyc_q[1] - grant_cyc_q[0]), 6);
    end

    // Simultaneous request: SFX first.
    got_q.delete();
    pace_cycles = 16'd2;
    music_valid = 1'b1; music_byte = 8'hA0;
    sfx_valid = 1'b1; sfx_byte = 8'h5B;
    tick();
    check("t3_sfx_first", 32'(took_s), 1);
    drain();
    check("t3_count", 32'(got_q.size()), 2);
    if (got_q.size() >= 2) begin
      check("t3_byte0", 32'(got_q[0]), 32'h15B);
      check("t3_byte1", 32'(got_q[1]), 32'h0A0);
    end

    // Starvation guard.
    got_q.delete();
    pace_cycles = 16'd0;
    exp4[0] = 9'h101; exp4[1] = 9'h102; exp4[2] = 9'h103; exp4[3] = 9'h080; exp4[4] = 9'h104;
    music_valid = 1'b1; music_byte = 8'h80;
    nxt = 1;
    for (int i = 0; i < 60 && got_q.size() < 5; i++) begin
      if (!sfx_valid && nxt <= 5) begin
        sfx_valid = 1'b1; sfx_byte = 8'(nxt); nxt++;
      end
      tick();
    end
    check("t4_count", 32'(got_q.size()), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < got_q.size()) check("t4_order", 32'(got_q[i]), 32'(exp4[i]));
    end
    drain();

    // Backpressure with competing SFX.
    got_q.delete();
    pace_cycles = 16'd1; out_ready = 1'b0;
    music_valid = 1'b1; music_byte = 8'h3C;
    tick();
    sfx_valid = 1'b1; sfx_byte = 8'h66;
    repeat (10) begin
      check("t5_hold_byte", 32'(out_byte), 32'h3C);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("t5_done", 32'(got_q.size()), 1);
    if (got_q.size() >= 1) check("t5_byte", 32'(got_q[0]), 32'h03C);
    drain();

    // Enable dropped right after a grant.
    got_q.delete();
    pace_cycles = 16'd0;
    music_valid = 1'b1; music_byte = 8'h77;
    tick();
    enable = 1'b0;
    tick();
    music_valid = 1'b1; music_byte = 8'h12;
    repeat (5) tick();
    check("t6_delivered", 32'(got_q.size()), 1);
    if (got_q.size() >= 1) check("t6_byte", 32'(got_q[0]), 32'h077);
    check("t6_parked_busy", 32'(busy), 0);
    enable = 1'b1;
    tick();
    check("t6_reenable_grant", 32'(took_m), 1);
    drain();

    // Reset in SEND drops the in-flight byte.
    got_q.delete();
    out_ready = 1'b0;
    music_valid = 1'b1; music_byte = 8'h99;
    tick();
    tick();
    ARESETN = 1'b0;
    #1;
    check("t1_rst_mid_send", 32'(out_valid), 0);
    music_valid = 1'b1; music_byte = 8'h44;
    tick();
    ARESETN = 1'b1; out_ready = 1'b1;
    drain();
    check("t1_fresh_count", 32'(got_q.size()), 1);
    if (got_q.size() >= 1) check("t1_fresh_byte", 32'(got_q[0]), 32'h044);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      if (!music_valid && $urandom_range(0, 2) == 0) begin
        music_valid = 1'b1; music_byte = 8'($urandom);
      end
      if (!sfx_valid && $urandom_range(0, 2) == 0) begin
        sfx_valid = 1'b1; sfx_byte = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) pace_cycles = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 39) == 0) enable = !enable;
      tick();
    end
    enable = 1'b1; out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
